// File: rtl/board_run_ctrl.sv
// board_run_ctrl: on-board run controller between switch/button/display I/O and a CPU core.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sw, arg_id, yes   argument value, index and load button
//   ready             start button (ENTRY -> RUN)
//   step_mode, step   single-step select and step button
//   halt              core halt indication, sampled only on tick candidates
//   dbg_sel, dbg_bus  display select and packed debug words
//   args              packed argument registers
//   cpu_tick          one-clk core advance pulse
//   core_rst          active-high core reset (high in ENTRY)
//   working, done     RUN / DONE state flags
//   cycle_cnt         ticks issued since entering RUN (saturating)
//   disp_data         registered word for the 7-segment driver
module board_run_ctrl #(
    parameter int NUM_ARGS = 2,
    parameter int ARG_W    = 32,
    parameter int SW_W     = 8,
    parameter int NUM_DBG  = 5,
    parameter int DIV      = 10000,
    parameter int IDW      = 1,
    parameter int SELW     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SW_W-1:0]           sw,
    input  logic [IDW-1:0]            arg_id,
    input  logic                      yes,
    input  logic                      ready,
    input  logic                      step_mode,
    input  logic                      step,
    input  logic                      halt,
    input  logic [SELW-1:0]           dbg_sel,
    input  logic [NUM_DBG*ARG_W-1:0]  dbg_bus,
    output logic [NUM_ARGS*ARG_W-1:0] args,
    output logic                      cpu_tick,
    output logic                      core_rst,
    output logic                      working,
    output logic                      done,
    output logic [31:0]               cycle_cnt,
    output logic [ARG_W-1:0]          disp_data
);
    localparam logic [1:0] ENTRY = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       yes_sh, ready_sh, step_sh;
    logic [1:0]       mode_sh;
    logic [31:0]      div_cnt;
    logic             yes_p, ready_p, step_p, cand;
    logic [ARG_W-1:0] disp_next;

    // bits [1:0] synchronise, bit 2 is the extra stage that sets the pulse latency, bit 3 is the edge reference
    assign yes_p    = yes_sh[2] & ~yes_sh[3];
    assign ready_p  = ready_sh[2] & ~ready_sh[3];
    assign step_p   = step_sh[2] & ~step_sh[3];
    assign cand     = mode_sh[1] ? step_p : (div_cnt == 32'(DIV - 1));
    assign core_rst = state == ENTRY;
    assign working  = state == RUN;
    assign done     = state == DONE;
    assign cpu_tick = working & cand & ~halt;

    always_comb begin
        disp_next = '0;
        if (state == ENTRY) begin
            for (int i = 0; i < NUM_ARGS; i++)
                if (arg_id == IDW'(i)) disp_next = args[i*ARG_W +: ARG_W];
        end else begin
            for (int i = 0; i < NUM_DBG; i++)
                if (dbg_sel == SELW'(i)) disp_next = dbg_bus[i*ARG_W +: ARG_W];
            if (dbg_sel == SELW'(NUM_DBG)) disp_next = ARG_W'(cycle_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENTRY;
            args      <= '0;
            cycle_cnt <= '0;
            div_cnt   <= '0;
            yes_sh    <= '0;
            ready_sh  <= '0;
            step_sh   <= '0;
            mode_sh   <= '0;
            disp_data <= '0;
        end else begin
            yes_sh    <= {yes_sh[2:0], yes};
            ready_sh  <= {ready_sh[2:0], ready};
            step_sh   <= {step_sh[2:0], step};
            mode_sh   <= {mode_sh[0], step_mode};
            disp_data <= disp_next;
            case (state)
                ENTRY: begin
                    if (yes_p)
                        for (int i = 0; i < NUM_ARGS; i++)
                            if (arg_id == IDW'(i)) args[i*ARG_W +: ARG_W] <= ARG_W'(sw);
                    if (ready_p) begin
                        state     <= RUN;
                        cycle_cnt <= '0;
                        div_cnt   <= '0;
                    end
                end
                RUN: begin
                    // step mode pins the divider at 0, so a mode switch always restarts the count
                    div_cnt <= (mode_sh[1] || div_cnt == 32'(DIV - 1)) ? '0 : div_cnt + 32'd1;
                    if (cand) begin
                        if (halt) state <= DONE;
                        else if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
                    end
                end
                DONE: if (yes_p) state <= ENTRY;
                default: state <= ENTRY;
            endcase
        end
    end
endmodule
